rst_sequencer: RTL

RST_SEQUENCER -- requirements
Module: rst_sequencer

---
 rtl/rst_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/rst_sequencer.sv
// Power-on / software reset sequencer: waits for a stable PLL lock, releases the
// peripheral reset, then the core reset after a stagger; any lock loss restarts it.
module rst_sequencer #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned STAGGER_CYCLES     = 16,
  parameter int unsigned SW_HOLD_CYCLES     = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       sw_rst_req,
  output logic       periph_rst,
  output logic       core_rst,
  output logic       ready,
  output logic [2:0] state,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned ST_W  = 3;
  localparam int unsigned LLC_W = 8;

  localparam logic [ST_W-1:0] S_HOLD    = 3'd0;
  localparam logic [ST_W-1:0] S_STABLE  = 3'd1;
  localparam logic [ST_W-1:0] S_STAGGER = 3'd2;
  localparam logic [ST_W-1:0] S_RUN     = 3'd3;
  localparam logic [ST_W-1:0] S_SWRST   = 3'd4;

  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] SW_LAST      = CNT_W'(SW_HOLD_CYCLES - 1);
  localparam logic [LLC_W-1:0] LLC_MAX      = '1;

  logic             lock_meta;
  logic             lock_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [ST_W-1:0]  state_nxt;
  logic             periph_rst_d;
  logic             core_rst_d;
  logic             count_loss;

  // Two-flop synchroniser; lock_s is the only view of pll_lock used below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // State register; reset outputs are loaded from the next-state decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_HOLD;
      cnt           <= '0;
      periph_rst    <= 1'b1;
      core_rst      <= 1'b1;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      periph_rst <= periph_rst_d;
      core_rst   <= core_rst_d;
      ready      <= ~core_rst_d;
      if (count_loss && (lock_loss_cnt != LLC_MAX)) begin
        lock_loss_cnt <= lock_loss_cnt + LLC_W'(1);
      end
    end
  end

  // Next-state: lock loss outranks everything, sw_rst_req only matters in RUN.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_HOLD: begin
        if (lock_s) state_nxt = S_STABLE;
      end
      S_STABLE: begin
        if (!lock_s)               state_nxt = S_HOLD;
        else if (cnt == LOCK_LAST) state_nxt = S_STAGGER;
        else                       cnt_nxt   = cnt + CNT_W'(1);
      end
      S_STAGGER: begin
        if (!lock_s)                  state_nxt = S_HOLD;
        else if (cnt == STAGGER_LAST) state_nxt = S_RUN;
        else                          cnt_nxt   = cnt + CNT_W'(1);
      end
      S_RUN: begin
        if (!lock_s)         state_nxt = S_HOLD;
        else if (sw_rst_req) state_nxt = S_SWRST;
      end
      S_SWRST: begin
        if (!lock_s)             state_nxt = S_HOLD;
        else if (cnt == SW_LAST) state_nxt = S_STAGGER;
        else                     cnt_nxt   = cnt + CNT_W'(1);
      end
      default: state_nxt = S_HOLD;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

  // Output decode of the upcoming state, plus lock-loss event detection.
  always_comb begin
    periph_rst_d = 1'b1;
    core_rst_d   = 1'b1;
    case (state_nxt)
      S_STAGGER: periph_rst_d = 1'b0;
      S_RUN: begin
        periph_rst_d = 1'b0;
        core_rst_d   = 1'b0;
      end
      default: ;
    endcase
    count_loss = (state_nxt == S_HOLD) &&
                 ((state == S_STAGGER) || (state == S_RUN) || (state == S_SWRST));
  end

endmodule
